uart_tx_fifo: RTL and testbench

//  Parametrised UART transmitter with an integrated transmit FIFO. It sits beside

---
 rtl/uart_tx_fifo_pkg.sv | 22 ++
 rtl/uart_tx_fifo_sync_fifo.sv | 63 ++++++
 rtl/uart_tx_fifo.sv | 131 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmitter: run-time parity encodings,
// transmit FSM state type and a small parity-mode helper.
package uart_tx_fifo_pkg;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // 2'b11 is treated the same as PARITY_NONE.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with a separately maintained occupancy counter.
// Ports:
//   clk, rst        clock, synchronous active-high reset (flushes contents)
//   push, wr_data   write request and data; accepted when not full or when
//                   a pop happens in the same clock
//   pop, rd_data    pop request (ignored when empty); rd_data shows the head
//   full, empty     occupancy flags
//   level           number of stored words
//   overflow        1-clk pulse when a push is dropped
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (level == '0);
  assign full     = (level == LW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with integrated TX FIFO, driven by an oversampling baud tick.
// Ports:
//   clk, rst      clock, synchronous active-high reset (aborts any frame)
//   tick          1-clk baud tick, OVERSAMPLE ticks per bit
//   wr_en/wr_data push a word into the FIFO
//   cfg_parity    00/11 none, 01 even, 10 odd (latched per frame)
//   cfg_stop2     1 = two stop bits (latched per frame)
//   tx            serial line, idle high
//   tx_done       1-clk pulse on the final tick of the last stop bit
//   busy          high while a frame occupies the line
//   fifo_full/fifo_empty/fifo_level  FIFO status
//   overflow      1-clk pulse when a write is dropped
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tick,
  input  logic                            wr_en,
  input  logic [DATA_BITS-1:0]            wr_data,
  input  logic [1:0]                      cfg_parity,
  input  logic                            cfg_stop2,
  output logic                            tx,
  output logic                            tx_done,
  output logic                            busy,
  output logic                            fifo_full,
  output logic                            fifo_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            overflow
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  tx_state_t              state;
  tx_state_t              state_next;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_en;
  logic                   par_val;
  logic                   stop2_q;
  logic [DATA_BITS-1:0]   fifo_rd_data;
  logic                   fifo_pop;
  logic                   bit_end;
  logic                   stop_last;
  logic                   frame_end;

  assign bit_end   = tick && (tick_cnt == TW'(OVERSAMPLE - 1)) && (state != ST_IDLE);
  assign stop_last = !stop2_q || (bit_cnt == BW'(1));
  assign frame_end = (state == ST_STOP) && bit_end && stop_last;
  // Pop from idle, or at the very end of a frame so the next one follows with no gap.
  assign fifo_pop  = !rst && !fifo_empty && ((state == ST_IDLE) || frame_end);

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_en && !rst),
    .pop      (fifo_pop),
    .wr_data  (wr_data),
    .rd_data  (fifo_rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level),
    .overflow (overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (fifo_pop) state_next = ST_START;
      ST_START:  if (bit_end) state_next = ST_DATA;
      ST_DATA:   if (bit_end && (bit_cnt == BW'(DATA_BITS - 1)))
                   state_next = par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_next = ST_STOP;
      ST_STOP:   if (frame_end) state_next = fifo_pop ? ST_START : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx      = 1'b1;
    busy    = (state != ST_IDLE);
    tx_done = frame_end && !rst;
    case (state)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shreg[0];
      ST_PARITY: tx = par_val;
      default:   tx = 1'b1;
    endcase
  end

  // Word and frame configuration are captured at pop, so later cfg changes
  // only affect the next frame. bit_cnt restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_en   <= 1'b0;
      par_val  <= 1'b0;
      stop2_q  <= 1'b0;
    end else if (fifo_pop) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= fifo_rd_data;
      par_en   <= parity_enabled(cfg_parity);
      par_val  <= (cfg_parity == PARITY_ODD) ? ~^fifo_rd_data : ^fifo_rd_data;
      stop2_q  <= cfg_stop2;
    end else if (tick && (state != ST_IDLE)) begin
      tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
      if (bit_end) begin
        bit_cnt <= (state_next != state) ? '0 : bit_cnt + 1'b1;
        if (state == ST_DATA) shreg <= shreg >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;
  logic       tx;
  logic       tx_done;
  logic       busy;
  logic       fifo_full;
  logic       fifo_empty;
  logic [2:0] fifo_level;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  uart_tx_fifo #(
    .DATA_BITS  (8),
    .FIFO_DEPTH (4),
    .OVERSAMPLE (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .tx         (tx),
    .tx_done    (tx_done),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-clock tick every fourth clock.
  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Waits for a start bit, then samples tx on every tick until tx_done.
  task automatic capture(output logic [11:0] bits, output int nticks, output int waitc,
                         output logic glitch, output logic busy_drop, output logic ok);
    logic found;
    logic done;
    bits = '0; nticks = 0; waitc = 0; glitch = 1'b0; busy_drop = 1'b0;
    found = 1'b0; done = 1'b0;
    while (!found && waitc < 3000) begin
      @(negedge clk);
      waitc++;
      if (tx === 1'b0) found = 1'b1;
    end
    for (int c = 0; c < 8000 && found && !done; c++) begin
      if (c != 0) @(negedge clk);
      if (busy !== 1'b1) busy_drop = 1'b1;
      if (tick === 1'b1) begin
        if (nticks / 16 < 12) begin
          if (nticks % 16 == 0) bits[nticks / 16] = tx;
          else if (tx !== bits[nticks / 16]) glitch = 1'b1;
        end
        nticks++;
      end
      if (tx_done === 1'b1) done = 1'b1;
    end
    ok = found && done;
  endtask

  task automatic frame(input string tag, input logic [11:0] exp_bits, input int exp_ticks,
                       output int waitc, output logic busy_drop);
    logic [11:0] bits;
    int          nticks;
    logic        glitch;
    logic        ok;
    capture(bits, nticks, waitc, glitch, busy_drop, ok);
    chk({tag, ".ok"},     32'(ok),     32'(1));
    chk({tag, ".bits"},   32'(bits),   32'(exp_bits));
    chk({tag, ".ticks"},  32'(nticks), 32'(exp_ticks));
    chk({tag, ".steady"}, 32'(glitch), 32'(0));
  endtask

  initial begin
    int   w0, w1, w2;
    logic bd0, bd1, bd2;
    int   cnt;
    int   done_seen;
    int   low_seen;

    rst = 1'b1; wr_en = 1'b0; wr_data = '0; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.tx",       32'(tx),         32'(1));
    chk("rst.tx_done",  32'(tx_done),    32'(0));
    chk("rst.busy",     32'(busy),       32'(0));
    chk("rst.overflow", 32'(overflow),   32'(0));
    chk("rst.empty",    32'(fifo_empty), 32'(1));
    chk("rst.full",     32'(fifo_full),  32'(0));
    chk("rst.level",    32'(fifo_level), 32'(0));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Plain 8N1 frame
    push_word(8'hA5);
    frame("n1", 12'({1'b1, 8'hA5, 1'b0}), 160, w0, bd0);
    chk("n1.busy", 32'(bd0), 32'(0));

    // Parity variants
    cfg_parity = 2'b01;
    push_word(8'hA5);
    frame("evenA5", 12'({1'b1, 1'b0, 8'hA5, 1'b0}), 176, w0, bd0);
    cfg_parity = 2'b10;
    push_word(8'hA5);
    frame("oddA5", 12'({1'b1, 1'b1, 8'hA5, 1'b0}), 176, w0, bd0);
    cfg_parity = 2'b01;
    push_word(8'h07);
    frame("even07", 12'({1'b1, 1'b1, 8'h07, 1'b0}), 176, w0, bd0);
    cfg_parity = 2'b11;
    push_word(8'h07);
    frame("p11", 12'({1'b1, 8'h07, 1'b0}), 160, w0, bd0);

    // Two stop bits, config changed mid-frame has no effect
    cfg_parity = 2'b00; cfg_stop2 = 1'b1;
    push_word(8'h07);
    fork
      frame("stop2", 12'({2'b11, 8'h07, 1'b0}), 176, w0, bd0);
      begin
        repeat (100) @(negedge clk);
        cfg_parity = 2'b10;
        cfg_stop2  = 1'b0;
      end
    join
    cfg_parity = 2'b00; cfg_stop2 = 1'b0;

    // Back-to-back frames
    fork
      begin
        @(negedge clk); wr_en = 1'b1; wr_data = 8'h11;
        @(negedge clk); wr_data = 8'h22;
        @(negedge clk); wr_data = 8'h33;
        @(negedge clk); wr_en = 1'b0;
      end
      begin
        frame("b2b0", 12'({1'b1, 8'h11, 1'b0}), 160, w0, bd0);
        frame("b2b1", 12'({1'b1, 8'h22, 1'b0}), 160, w1, bd1);
        frame("b2b2", 12'({1'b1, 8'h33, 1'b0}), 160, w2, bd2);
      end
    join
    chk("b2b.gap1",  32'(w1), 32'(1));
    chk("b2b.gap2",  32'(w2), 32'(1));
    chk("b2b.busy",  32'(bd0 | bd1 | bd2), 32'(0));
    chk("b2b.empty", 32'(fifo_empty), 32'(1));
    @(negedge clk);
    chk("b2b.idle_busy", 32'(busy), 32'(0));
    repeat (4) @(negedge clk);

    // Overflow burst: 6 writes into depth-4 FIFO while idle
    fork
      begin
        @(negedge clk); wr_en = 1'b1; wr_data = 8'h01;
        @(negedge clk); wr_data = 8'h02;
        @(negedge clk); wr_data = 8'h03;
        @(negedge clk); wr_data = 8'h04;
        @(negedge clk); wr_data = 8'h05;
        #1 chk("ovf.w5_overflow", 32'(overflow), 32'(0));
        @(negedge clk); wr_data = 8'h06;
        #1 chk("ovf.w6_overflow", 32'(overflow), 32'(1));
        chk("ovf.w6_full", 32'(fifo_full), 32'(1));
        @(negedge clk); wr_en = 1'b0;
        #1 chk("ovf.full", 32'(fifo_full), 32'(1));
        chk("ovf.level", 32'(fifo_level), 32'(4));
        chk("ovf.pulse_end", 32'(overflow), 32'(0));
      end
      begin
        frame("ovf0", 12'({1'b1, 8'h01, 1'b0}), 160, w0, bd0);
        frame("ovf1", 12'({1'b1, 8'h02, 1'b0}), 160, w0, bd0);
        frame("ovf2", 12'({1'b1, 8'h03, 1'b0}), 160, w0, bd0);
        frame("ovf3", 12'({1'b1, 8'h04, 1'b0}), 160, w0, bd0);
        frame("ovf4", 12'({1'b1, 8'h05, 1'b0}), 160, w0, bd0);
      end
    join
    chk("ovf.drained", 32'(fifo_empty), 32'(1));
    repeat (40) @(negedge clk);
    chk("ovf.no_sixth", 32'(tx), 32'(1));

    // Reset in the middle of data bit 3, with a second word queued
    push_word(8'h5A);
    cnt = 0;
    while (tx !== 1'b0 && cnt < 100) begin @(negedge clk); cnt++; end
    chk("mid.started", 32'(tx), 32'(0));
    cnt = 0;
    while (cnt < 40) begin @(negedge clk); if (tick === 1'b1) cnt++; end
    push_word(8'h66);
    while (cnt < 70) begin @(negedge clk); if (tick === 1'b1) cnt++; end
    chk("mid.level", 32'(fifo_level), 32'(1));
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    #1 chk("mid.rst_no_done", 32'(tx_done), 32'(0));
    @(negedge clk);
    chk("mid.tx",    32'(tx),         32'(1));
    chk("mid.busy",  32'(busy),       32'(0));
    chk("mid.empty", 32'(fifo_empty), 32'(1));
    chk("mid.level0",32'(fifo_level), 32'(0));
    chk("mid.done",  32'(tx_done),    32'(0));
    rst = 1'b0; wr_en = 1'b0;
    done_seen = 0; low_seen = 0;
    repeat (400) begin
      @(negedge clk);
      if (tx_done === 1'b1) done_seen++;
      if (tx !== 1'b1) low_seen++;
    end
    chk("mid.quiet_done", 32'(done_seen), 32'(0));
    chk("mid.quiet_tx",   32'(low_seen),  32'(0));
    chk("mid.wr_in_rst",  32'(fifo_empty), 32'(1));
    push_word(8'h3C);
    frame("post", 12'({1'b1, 8'h3C, 1'b0}), 160, w0, bd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
